// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, xtime, key-size helpers and key-schedule types.
package aes_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic int nk(input int key_bits);
      return key_bits / 32;
   endfunction

   function automatic int nr(input int key_bits);
      return key_bits / 32 + 6;
   endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Bundle between the key schedule (slave) and its controller/round datapath (master).
interface aes_key_schedule_if #(parameter int KEY_BITS = 128) ();
   import aes_pkg::*;

   // round_key/round_idx transfer when rk_valid && rk_ready at a rising edge; once raised,
   // rk_valid and the payload hold until that transfer happens.
   logic                start;
   logic [KEY_BITS-1:0] key;
   logic                busy;
   logic                rk_valid;
   logic                rk_ready;
   logic [127:0]        round_key;
   logic [3:0]          round_idx;
   logic                done;
   logic [3:0]          rd_addr;
   logic [127:0]        rd_data;
   state_t              state;

   modport master (
      output start, key, rk_ready, rd_addr,
      input  busy, rk_valid, round_key, round_idx, done, rd_data, state
   );

   modport slave (
      input  start, key, rk_ready, rd_addr,
      output busy, rk_valid, round_key, round_idx, done, rd_data, state
   );

endinterface

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_sub_word
   import aes_pkg::*;
(
   input  word_t word,
   output word_t sub
);

   assign sub[31:24] = SBOX[word[31:24]];
   assign sub[23:16] = SBOX[word[23:16]];
   assign sub[15:8]  = SBOX[word[15:8]];
   assign sub[7:0]   = SBOX[word[7:0]];

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES key expansion: one word per cycle, round keys streamed over valid/ready.
// Define KEYSCHED_STORE_EN to retain all round keys for indexed (reverse-order) readout.
module aes_key_schedule
   import aes_pkg::*;
#(
   parameter int KEY_BITS = 128
)(
   input logic clk,
   input logic reset,
   aes_key_schedule_if.slave bus
);

   localparam int NK        = nk(KEY_BITS);
   localparam int NR        = nr(KEY_BITS);
   localparam int LAST_WORD = 4 * (NR + 1) - 1;

   state_t       state_q, state_d;
   logic [5:0]   word_cnt;
   logic [2:0]   mod_cnt;
   logic [7:0]   rcon;
   word_t        win [NK];
   word_t        asm_w [4];
   logic [1:0]   fill;
   logic [3:0]   asm_idx;
   logic         accept, produce, key_load, hs, last_hs;
   word_t        sub_in, sub_out, w_new;
   logic [127:0] new_key;

   aes_sub_word u_sub_word (.word(sub_in), .sub(sub_out));

   always_comb begin
      hs       = bus.rk_valid && bus.rk_ready;
      accept   = (state_q == IDLE) && bus.start;
      produce  = (state_q == EXPAND) && !(bus.rk_valid && !bus.rk_ready);
      key_load = produce && (fill == 2'd3);
      last_hs  = (state_q == DRAIN) && hs;
   end

   // win[0] is w[i-Nk], win[NK-1] is w[i-1]; the first Nk words rotate the loaded key through.
   always_comb begin
      sub_in = (mod_cnt == 3'd0) ? {win[NK-1][23:0], win[NK-1][31:24]} : win[NK-1];
      if (word_cnt < 6'(NK))
         w_new = win[0];
      else if (mod_cnt == 3'd0)
         w_new = win[0] ^ sub_out ^ {rcon, 24'h0};
      else if (NK == 8 && mod_cnt == 3'd4)
         w_new = win[0] ^ sub_out;
      else
         w_new = win[0] ^ win[NK-1];
      new_key = {asm_w[0], asm_w[1], asm_w[2], w_new};
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = EXPAND;
         EXPAND:  if (produce && word_cnt == 6'(LAST_WORD)) state_d = DRAIN;
         DRAIN:   if (hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy  = (state_q != IDLE);
      bus.state = state_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         word_cnt      <= '0;
         mod_cnt       <= '0;
         rcon          <= '0;
         fill          <= '0;
         asm_idx       <= '0;
         bus.rk_valid  <= 1'b0;
         bus.round_key <= '0;
         bus.round_idx <= '0;
         bus.done      <= 1'b0;
      end else begin
         bus.done <= last_hs;
         if (accept) begin
            word_cnt <= '0;
            mod_cnt  <= '0;
            rcon     <= 8'h01;
            fill     <= '0;
            asm_idx  <= '0;
         end else if (produce) begin
            word_cnt <= word_cnt + 6'd1;
            mod_cnt  <= (mod_cnt == 3'(NK-1)) ? 3'd0 : mod_cnt + 3'd1;
            if (word_cnt >= 6'(NK) && mod_cnt == 3'd0) rcon <= xtime(rcon);
            fill <= fill + 2'd1;
            if (key_load) asm_idx <= asm_idx + 4'd1;
         end
         // A fresh key landing on a handshake edge keeps rk_valid high.
         if (key_load) begin
            bus.rk_valid  <= 1'b1;
            bus.round_key <= new_key;
            bus.round_idx <= asm_idx;
         end else if (hs) begin
            bus.rk_valid  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int j = 0; j < NK; j++) win[j] <= bus.key[KEY_BITS-1-32*j -: 32];
      end else if (produce) begin
         for (int j = 0; j < NK-1; j++) win[j] <= win[j+1];
         win[NK-1]   <= w_new;
         asm_w[fill] <= w_new;
      end
   end

`ifdef KEYSCHED_STORE_EN
   logic [127:0] store [15];

   // The key store survives reset so a decryption pass can still read it.
   always_ff @(posedge clk) begin
      if (key_load && !reset) store[asm_idx] <= new_key;
   end

   always_ff @(posedge clk) begin
      if (reset)                         bus.rd_data <= '0;
      else if (bus.rd_addr <= 4'(NR))    bus.rd_data <= store[bus.rd_addr];
      else                               bus.rd_data <= '0;
   end
`else
   logic unused_rd_addr;
   assign unused_rd_addr = ^bus.rd_addr;
   assign bus.rd_data    = '0;
`endif

endmodule
